instr_sequencer: RTL

//  Multi-cycle instruction sequencer for the 8-bit picoMIPS core. Owns the PC and steps each

---
 rtl/instr_seq_if.sv | 28 ++
 rtl/instr_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_seq_if.sv
// Bus between the instruction sequencer and its surroundings: instruction
// memory address / IR strobe, decoder hand-off, register-file write strobe and
// the IN/OUT valid/ready handshakes.
interface instr_seq_if #(
  parameter int PC_WIDTH = 8
);
  logic [3:0]          opcode;
  logic                dec_reg_we;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] pc;
  logic                ir_load;
  logic                reg_we;

  // Sequencer side
  modport master (
    input  opcode, dec_reg_we, in_valid, out_ready,
    output in_ready, out_valid, pc, ir_load, reg_we
  );

  // Core / environment side
  modport slave (
    output opcode, dec_reg_we, in_valid, out_ready,
    input  in_ready, out_valid, pc, ir_load, reg_we
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit picoMIPS core.
// Owns the PC and walks every instruction through FETCH, DECODE, an optional
// MUL or IN/OUT wait, and WB. All strobes are registered and decoded from the
// next state so they line up with the state they belong to.
module instr_sequencer #(
  parameter int PC_WIDTH   = 8,
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        halted,
  output logic [2:0]  state,
  instr_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MULW   = 3'd3,
    S_IOWAIT = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_IN   = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b1100;

  localparam logic [3:0]          MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          mul_cnt_q, mul_cnt_d;
  logic                io_dir_q, io_dir_d;   // 0 = IN, 1 = OUT
  logic                ir_load_q;
  logic                wb_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                halted_q;

  // Next-state and datapath-register update rules
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mul_cnt_d = mul_cnt_q;
    io_dir_d  = io_dir_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_HALT: state_d = S_HALTED;
          OP_MUL: begin
            state_d   = S_MULW;
            mul_cnt_d = MUL_LOAD;
          end
          OP_IN: begin
            state_d  = S_IOWAIT;
            io_dir_d = 1'b0;
          end
          OP_OUT: begin
            state_d  = S_IOWAIT;
            io_dir_d = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MULW: begin
        if (mul_cnt_q == 4'd0) state_d = S_WB;
        else                   mul_cnt_d = mul_cnt_q - 4'd1;
      end
      S_IOWAIT: begin
        // The transfer completes on the cycle both sides agree; no timeout.
        if ((!io_dir_q && bus.in_valid && in_ready_q) ||
            ( io_dir_q && bus.out_ready && out_valid_q))
          state_d = S_WB;
      end
      S_WB: begin
        pc_d    = pc_q + PC_ONE;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and registered Moore strobes; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mul_cnt_q   <= 4'd0;
      io_dir_q    <= 1'b0;
      ir_load_q   <= 1'b0;
      wb_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mul_cnt_q   <= mul_cnt_d;
      io_dir_q    <= io_dir_d;
      ir_load_q   <= (state_d == S_FETCH);
      wb_q        <= (state_d == S_WB);
      in_ready_q  <= (state_d == S_IOWAIT) && !io_dir_d;
      out_valid_q <= (state_d == S_IOWAIT) &&  io_dir_d;
      halted_q    <= (state_d == S_HALTED);
    end
  end

  // The decoder's write enable only reaches the register file during WB
  assign bus.reg_we    = wb_q & bus.dec_reg_we;
  assign bus.ir_load   = ir_load_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pc        = pc_q;
  assign halted        = halted_q;
  assign state         = state_q;

endmodule
